// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multicycle MIPS control path: opcodes, FSM state
// encodings, ALU operation codes and datapath mux selects.
package mips_ctrl_pkg;

  localparam int CTRL_STATE_W = 4;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  typedef enum logic [CTRL_STATE_W-1:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_EXECUTE   = 4'd7,
    S_R_WB      = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_ADDI_EXEC = 4'd11,
    S_ADDI_WB   = 4'd12
  } state_t;

  // Full set of datapath controls driven by the FSM in one bundle.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic       alu_src_a;
    logic       reg_write;
    logic       reg_dst;
    logic [1:0] pc_source;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       illegal_op;
  } ctrl_t;

  function automatic logic is_known_op(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: return 1'b1;
      default:                                       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_fsm.sv
// Main control FSM for the multicycle MIPS datapath: sequences fetch, decode,
// execute, memory and writeback, and decodes every datapath control from state.
module multicycle_control_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic [5:0]         Op,
  input  logic               Mem_Ready,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               MemtoReg,
  output logic               IRWrite,
  output logic               ALUSrcA,
  output logic               RegWrite,
  output logic               RegDst,
  output logic [1:0]         PCSource,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ALU_op,
  output logic               Illegal_Op,
  output logic [STATE_W-1:0] State
);

  state_t state_q;
  logic   run_q;
  ctrl_t  ctrl;

  // run_q delays leaving IDLE by one edge after reset release, so the first
  // FETCH lands on the second rising edge and never on the release edge itself.
  // NOTE: sequential state uses non-blocking assignments and an async active-low
  // clear, so reset takes effect immediately and all flops update together.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= S_IDLE;
      run_q   <= 1'b0;
    end else begin
      run_q <= 1'b1;
      case (state_q)
        S_IDLE:      if (run_q) state_q <= S_FETCH;
        S_FETCH:     if (Mem_Ready) state_q <= S_DECODE;
        S_DECODE: begin
          case (Op)
            OP_LW, OP_SW: state_q <= S_MEM_ADDR;
            OP_RTYPE:     state_q <= S_EXECUTE;
            OP_BEQ:       state_q <= S_BRANCH;
            OP_J:         state_q <= S_JUMP;
            OP_ADDI:      state_q <= S_ADDI_EXEC;
            default:      state_q <= S_FETCH;
          endcase
        end
        // Only lw/sw reach MEM_ADDR, so anything other than lw is a store.
        S_MEM_ADDR:  state_q <= (Op == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
        S_MEM_READ:  if (Mem_Ready) state_q <= S_MEM_WB;
        S_MEM_WB:    state_q <= S_FETCH;
        S_MEM_WRITE: if (Mem_Ready) state_q <= S_FETCH;
        S_EXECUTE:   state_q <= S_R_WB;
        S_R_WB:      state_q <= S_FETCH;
        S_BRANCH:    state_q <= S_FETCH;
        S_JUMP:      state_q <= S_FETCH;
        S_ADDI_EXEC: state_q <= S_ADDI_WB;
        S_ADDI_WB:   state_q <= S_FETCH;
        default:     state_q <= S_FETCH;
      endcase
    end
  end

  // Outputs are a pure function of state, apart from the FETCH write strobes
  // (gated by Mem_Ready) and Illegal_Op (decoded from Op in DECODE).
  // NOTE: ctrl is cleared to zero before the case so every path assigns every
  // field and no latch is inferred.
  always_comb begin
    ctrl = '0;
    case (state_q)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.ir_write  = Mem_Ready;
        ctrl.pc_write  = Mem_Ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b  = SRCB_IMM_SH2;
        ctrl.alu_op     = ALU_ADD;
        ctrl.illegal_op = !is_known_op(Op);
      end
      S_MEM_ADDR, S_ADDI_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      S_EXECUTE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_B;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
      S_ADDI_WB: ctrl.reg_write = 1'b1;
      default: ctrl = '0;
    endcase
  end

  assign PCWrite     = ctrl.pc_write;
  assign PCWriteCond = ctrl.pc_write_cond;
  assign IorD        = ctrl.i_or_d;
  assign MemRead     = ctrl.mem_read;
  assign MemWrite    = ctrl.mem_write;
  assign MemtoReg    = ctrl.mem_to_reg;
  assign IRWrite     = ctrl.ir_write;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign RegWrite    = ctrl.reg_write;
  assign RegDst      = ctrl.reg_dst;
  assign PCSource    = ctrl.pc_source;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign ALU_op      = ctrl.alu_op;
  assign Illegal_Op  = ctrl.illegal_op;
  assign State       = STATE_W'(state_q);

endmodule
